gr_bin: RTL and testbench
=========================

Name: gr_bin

Overview:
- Registered Gray-code to binary converter.
- Takes a WIDTH-bit reflected-binary Gray word and returns its binary equivalent one clock later, with a valid qualifier.
- Sits at the boundary where Gray-coded values arrive (encoder positions, CDC pointers) and must be converted to binary for arithmetic.
- Datapath is purely bitwise XOR; no arithmetic carries.

Parameters:
- WIDTH, 8, bit width of din and dout; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  din is valid this cycle.
- din  input  WIDTH  Gray-coded input word.
- out_valid  output  1  dout carries a new conversion result this cycle.
- dout  output  WIDTH  binary result, registered.
- seq_err  output  1  Gray sequence error flag; present only when GR_BIN_CHECK_EN is defined.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, named rst.
- While rst is high: dout = 0, out_valid = 0, seq_err = 0 (when present).
- Release of rst takes effect on the next rising clk edge.
- Conversion function:
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
  - Equivalently, b[i] = XOR of g[WIDTH-1:i].
- Latency is exactly 1 cycle:
  - On a rising clk edge with in_valid = 1, dout <= convert(din) and out_valid <= 1.
  - On a rising clk edge with in_valid = 0, out_valid <= 0 and dout holds its last value. dout does not return to 0.
- Throughput: one word per cycle, with no back-pressure and no ready signal.
- din is sampled only when in_valid = 1. X/garbage on din while in_valid = 0 must not disturb dout.
- Boundaries:
  - All-zero input gives 0.
  - Input with only the MSB set gives all-ones.
  - There is no wrap or overflow; every one of the 2^WIDTH inputs maps to a unique output (bijection).
- Reset asserted mid-stream: outputs clear immediately, asynchronously. The in-flight word is discarded.
- The conversion logic must be a generate loop or a for loop over WIDTH. Hard-coding 8 bits is not acceptable.

Optional Feature:
- Macro GR_BIN_CHECK_EN.
- When defined:
  - The block keeps a registered copy of the last accepted din plus a "have previous" bit. Both are cleared by rst.
  - On each accepted word after the first, seq_err <= 1 for one cycle, aligned with out_valid, if popcount(din XOR prev_din) is not equal to 1.
  - A repeated value (popcount 0) counts as an error.
  - Otherwise seq_err <= 0.
  - seq_err is 0 for the first accepted word after reset, and 0 whenever out_valid = 0.
  - The conversion result is unaffected by the check.
- When undefined: the seq_err port and all checking logic are absent; interface and behaviour are otherwise identical.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> dout = 0x00 and out_valid = 0 immediately. After release and one valid word 0x03 -> dout = 0x02, out_valid = 1 on the next edge.
- Directed values, WIDTH = 8:
  - 0x00 -> 0x00
  - 0x01 -> 0x01
  - 0x03 -> 0x02
  - 0x02 -> 0x03
  - 0x80 -> 0xFF
  - 0xC0 -> 0x80
  - 0xAA -> 0xCC
  - each result appears 1 cycle after the input.
- Exhaustive sweep: for n = 0..255, drive din = n XOR (n>>1) with in_valid = 1 every cycle -> dout = n one cycle later, out_valid held at 1 for 256 cycles. Each step also checks the mapping is a bijection.
- Valid gating: drive in_valid = 0 with din = 0xFF after a valid 0x03 -> out_valid = 0, dout holds 0x02.
- Mid-stream reset: pulse rst during the sweep at n = 100 -> outputs 0 at once. Restart from n = 0 gives a correct sequence.
- GR_BIN_CHECK_EN:
  - Sequence 0x00, 0x01, 0x03, 0x03, 0x05 -> seq_err = 0, 0, 0, 1, 1.
  - 0x03 to 0x03 is a repeat; 0x03 to 0x05 differs in 2 bits.
  - First word after reset never flags.

Source files
------------

// File: rtl/gr_bin.sv
// Registered Gray-code to binary converter with a one-cycle latency and valid qualifier.
// Define GR_BIN_CHECK_EN to add the seq_err output that flags non-unit-distance Gray steps.
module gr_bin #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
`ifdef GR_BIN_CHECK_EN
  output logic             seq_err,
`endif
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] dout_q;
  logic             out_valid_q;

  // Each binary bit is the reduction XOR of the Gray bits at and above it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_conv
    assign bin_d[gi] = ^din[WIDTH-1:gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        dout_q <= bin_d;
      end
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

`ifdef GR_BIN_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q;
  logic             seq_err_q;
  logic [WIDTH-1:0] diff;
  logic             one_bit_d;

  // Exactly one bit differs when the difference is nonzero and a power of two.
  assign diff      = din ^ prev_q;
  assign one_bit_d = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else if (in_valid) begin
      prev_q      <= din;
      have_prev_q <= 1'b1;
      seq_err_q   <= have_prev_q && !one_bit_d;
    end else begin
      seq_err_q   <= 1'b0;
    end
  end

  assign seq_err = seq_err_q;
`endif

endmodule

// File: tb/tb_gr_bin.sv
// Self-checking bench for gr_bin at WIDTH=8: directed table, hand sequences, exhaustive sweep.
// Sequence-check vectors run only when GR_BIN_CHECK_EN is defined.
module tb_gr_bin;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic [WIDTH-1:0] dout;
`ifdef GR_BIN_CHECK_EN
  logic             seq_err;
`endif

  int total;
  int bad;

  gr_bin #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din       (din),
    .out_valid (out_valid),
`ifdef GR_BIN_CHECK_EN
    .seq_err   (seq_err),
`endif
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] g;
  bit               seen [256];

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{8'h00, 8'h00};
    tbl[1] = '{8'h01, 8'h01};
    tbl[2] = '{8'h03, 8'h02};
    tbl[3] = '{8'h02, 8'h03};
    tbl[4] = '{8'h80, 8'hFF};
    tbl[5] = '{8'hC0, 8'h80};
    tbl[6] = '{8'hAA, 8'hCC};

    rst      = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    #1;
    chk("reset_dout", 64'(dout), 64'h0);
    chk("reset_valid", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table, back-to-back valid words
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tbl[i].g);
      $display("vec %0d: din=0x%02h dout=0x%02h out_valid=%0b", i, tbl[i].g, dout, out_valid);
      chk("table_dout", 64'(dout), 64'(tbl[i].b));
      chk("table_valid", 64'(out_valid), 64'h1);
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    drive(1'b1, 8'h03);
    #2 rst = 1'b1;
    #1;
    $display("async reset: dout=0x%02h out_valid=%0b", dout, out_valid);
    chk("async_rst_dout", 64'(dout), 64'h0);
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;
    drive(1'b0, 8'h00);
    chk("post_rst_idle_valid", 64'(out_valid), 64'h0);
    drive(1'b1, 8'h03);
    $display("after reset: din=0x03 dout=0x%02h out_valid=%0b", dout, out_valid);
    chk("post_rst_dout", 64'(dout), 64'h02);
    chk("post_rst_valid", 64'(out_valid), 64'h1);

    // Valid gating: garbage on din with in_valid low must not disturb dout
    drive(1'b0, 8'hFF);
    $display("gated: din=0xFF in_valid=0 dout=0x%02h out_valid=%0b", dout, out_valid);
    chk("gate_valid", 64'(out_valid), 64'h0);
    chk("gate_hold", 64'(dout), 64'h02);
    drive(1'b0, 8'h5A);
    chk("gate_hold2", 64'(dout), 64'h02);

    // Sweep interrupted by reset at n = 100
    for (int n = 0; n <= 100; n++) begin
      g = 8'(n) ^ (8'(n) >> 1);
      drive(1'b1, g);
      chk("sweep1_dout", 64'(dout), 64'(n));
      chk("sweep1_valid", 64'(out_valid), 64'h1);
    end
    #2 rst = 1'b1;
    #1;
    $display("mid-sweep reset: dout=0x%02h out_valid=%0b", dout, out_valid);
    chk("mid_rst_dout", 64'(dout), 64'h0);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;

    // Full exhaustive sweep with bijection tracking
    for (int n = 0; n < 256; n++) seen[n] = 1'b0;
    for (int n = 0; n < 256; n++) begin
      g = 8'(n) ^ (8'(n) >> 1);
      drive(1'b1, g);
      chk("sweep_dout", 64'(dout), 64'(n));
      chk("sweep_valid", 64'(out_valid), 64'h1);
      chk("sweep_unique", 64'(seen[dout]), 64'h0);
      seen[dout] = 1'b1;
    end
    $display("sweep: 256 words converted");
    drive(1'b0, 8'h00);
    chk("sweep_end_valid", 64'(out_valid), 64'h0);
    chk("sweep_end_hold", 64'(dout), 64'hFF ^ 64'h00 & 64'hFF ? 64'(8'd255) : 64'h0);

`ifdef GR_BIN_CHECK_EN
    begin
      logic [7:0] sq  [5];
      logic       err [5];
      sq[0] = 8'h00; err[0] = 1'b0;
      sq[1] = 8'h01; err[1] = 1'b0;
      sq[2] = 8'h03; err[2] = 1'b0;
      sq[3] = 8'h03; err[3] = 1'b1;
      sq[4] = 8'h05; err[4] = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("chk_rst_err", 64'(seq_err), 64'h0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, sq[i]);
        $display("seq %0d: din=0x%02h seq_err=%0b", i, sq[i], seq_err);
        chk("seq_err", 64'(seq_err), 64'(err[i]));
      end
      drive(1'b0, 8'h00);
      chk("seq_err_idle", 64'(seq_err), 64'h0);
      // A 2-bit jump right after reset is still the first word and must not flag
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      drive(1'b1, 8'hFF);
      chk("seq_first_word", 64'(seq_err), 64'h0);
      drive(1'b1, 8'h7F);
      chk("seq_one_bit", 64'(seq_err), 64'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
